// File: rtl/res4b_serial_if.sv
// Handshake and operand bundle for the bit-serial subtractor.
// Master launches operations; slave returns results.
interface res4b_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] xi;
  logic [WIDTH-1:0] yi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] zi;
  logic             bo;
  logic             ov;

  modport master (
    output start, xi, yi,
    input  busy, done, zi, bo, ov
  );

  modport slave (
    input  start, xi, yi,
    output busy, done, zi, bo, ov
  );
endinterface

// File: rtl/res4b_serial.sv
// Bit-serial subtractor: one full-adder cell computes x + ~y + 1,
// LSB first, one bit per clock, with start/busy/done handshake.
module res4b_serial #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  res4b_serial_if.slave     bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SUB
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_zi;
  logic             r_bo;
  logic             r_ov;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_r_next;

  assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c = (r_a[0] & r_b[0])
             | (r_a[0] & r_carry)
             | (r_b[0] & r_carry);
  assign w_r_next = {w_s, r_r[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zi    <= '0;
      r_bo    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.xi;
            r_b     <= ~bus.yi;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          r_r     <= w_r_next;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // r_carry here is the carry into the MSB
            r_zi    <= w_r_next;
            r_bo    <= ~w_c;
            r_ov    <= r_carry ^ w_c;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.zi   = r_zi;
  assign bus.bo   = r_bo;
  assign bus.ov   = r_ov;
endmodule

// File: tb/tb_res4b_serial.sv
// Directed bench for res4b_serial: reset, arithmetic cases,
// handshake corner cases and reset during an operation.
module tb_res4b_serial;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  res4b_serial_if #(.WIDTH(W)) bus ();

  res4b_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_done(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.xi    = '0;
    bus.yi    = '0;
    #1;
    n_chk++;
    if ({bus.busy, bus.done, bus.zi, bus.bo, bus.ov} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b done=%b zi=%h bo=%b ov=%b want all 0",
               bus.busy, bus.done, bus.zi, bus.bo, bus.ov);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle: got busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
  endtask

  task automatic test_sub(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [W-1:0] ez,
    input logic         ebo,
    input logic         eov
  );
    int n;
    bit ok;
    bus.xi    = x;
    bus.yi    = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_chk++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy %h-%h: got %b want 1", x, y, bus.busy);
    end
    wait_done(n, ok);
    n_chk++;
    if (!ok || n != 4) begin
      n_fail++;
      $display("FAIL latency %h-%h: got ok=%0d n=%0d want ok=1 n=4",
               x, y, ok, n);
    end
    n_chk++;
    if ({bus.zi, bus.bo, bus.ov} !== {ez, ebo, eov}) begin
      n_fail++;
      $display("FAIL result %h-%h: got zi=%h bo=%b ov=%b want %h %b %b",
               x, y, bus.zi, bus.bo, bus.ov, ez, ebo, eov);
    end
    @(negedge clk);
    n_chk++;
    if (bus.done !== 1'b0 || bus.zi !== ez) begin
      n_fail++;
      $display("FAIL done_fall %h-%h: got done=%b zi=%h want 0 %h",
               x, y, bus.done, bus.zi, ez);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    bus.xi    = 4'h5;
    bus.yi    = 4'h5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.xi = 4'hF;
    bus.yi = 4'h1;
    wait_done(n, ok);
    n_chk++;
    if (!ok || bus.zi !== 4'h0 || bus.bo !== 1'b0 || bus.ov !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_start: got ok=%0d zi=%h bo=%b ov=%b want 1 0 0 0",
               ok, bus.zi, bus.bo, bus.ov);
    end
    @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b1 || bus.zi !== 4'h0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b zi=%h want 1 0",
               bus.busy, bus.zi);
    end
    wait_done(n, ok);
    bus.start = 1'b0;
    n_chk++;
    if (!ok || n != W) begin
      n_fail++;
      $display("FAIL b2b_spacing: got ok=%0d n=%0d want 1 %0d",
               ok, n + 1, W + 1);
    end
    n_chk++;
    if ({bus.zi, bus.bo, bus.ov} !== {4'hE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_result: got zi=%h bo=%b ov=%b want E 0 0",
               bus.zi, bus.bo, bus.ov);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    bit ok;
    bus.xi    = 4'h6;
    bus.yi    = 4'h6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.xi    = 4'h9;
    bus.yi    = 4'h3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n, ok);
    n_chk++;
    if (!ok || n != 2 || bus.zi !== 4'h0 || bus.bo !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: got ok=%0d n=%0d zi=%h bo=%b want 1 2 0 0",
               ok, n, bus.zi, bus.bo);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    bus.xi    = 4'h9;
    bus.yi    = 4'h2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.busy, bus.done, bus.zi, bus.bo, bus.ov} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_rst: got busy=%b done=%b zi=%h bo=%b ov=%b want 0",
               bus.busy, bus.done, bus.zi, bus.bo, bus.ov);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    n_chk++;
    if (seen || bus.zi !== 4'h0) begin
      n_fail++;
      $display("FAIL no_done_after_rst: got done=%b zi=%h want 0 0",
               seen, bus.zi);
    end
    test_sub(4'h9, 4'h2, 4'h7, 1'b0, 1'b1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_sub(4'h7, 4'h3, 4'h4, 1'b0, 1'b0);
    test_sub(4'h3, 4'h7, 4'hC, 1'b1, 1'b0);
    test_sub(4'h7, 4'hF, 4'h8, 1'b1, 1'b1);
    test_sub(4'h8, 4'h1, 4'h7, 1'b0, 1'b1);
    test_sub(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    test_sub(4'h0, 4'h1, 4'hF, 1'b1, 1'b0);
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
